// File: rtl/ring_decoder.sv
// ring_decoder: receive-side decoder/monitor for a one-hot ring counter bus.
// Samples a WIDTH-bit ring code, decodes it to a binary phase index, checks
// one-hot legality and shift-right rotation order, tracks lock and keeps a
// saturating error count. All outputs are registered (1 clk latency).
//
// Optional build macro: RING_ERR_STICKY_EN
//   Adds err_clr input and err_sticky output. err_sticky latches any error
//   until err_clr is seen on a clock edge, which also clears err_cnt. An
//   error in the same cycle as err_clr wins.
//
// Handshake: ring_vld qualifies ring_in for exactly the cycle it is high;
// there is no backpressure. Each valid sample produces exactly one of
// phase_vld or illegal (plus seq_err alongside phase_vld on an order error)
// one clock later; cycles without ring_vld produce no pulses.
//
// The lock FSM register is the signal 'state' (type lock_state_t) for
// checker binding.
module ring_decoder #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         ring_in,
  input  logic                     ring_vld,
`ifdef RING_ERR_STICKY_EN
  input  logic                     err_clr,
  output logic                     err_sticky,
`endif
  output logic [$clog2(WIDTH)-1:0] phase,
  output logic                     phase_vld,
  output logic                     illegal,
  output logic                     seq_err,
  output logic                     locked,
  output logic [ERR_W-1:0]         err_cnt
);

  localparam int PW = $clog2(WIDTH);
  localparam int RW = $clog2(LOCK_CNT + 1);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } lock_state_t;

  lock_state_t      state;
  logic [WIDTH-1:0] prev;
  logic             have_prev;
  logic [RW-1:0]    run;

  logic             is_legal;
  logic             in_order;
  logic [WIDTH-1:0] expected;
  logic [PW-1:0]    dec_phase;
  logic [RW-1:0]    run_inc;
  logic             err_now;
  logic [ERR_W-1:0] err_inc;

  // Priority-free decode: for a legal one-hot code only one bit matches.
  always_comb begin
    dec_phase = '0;
    for (int p = 0; p < WIDTH; p++) begin
      if (ring_in[p]) dec_phase = PW'(WIDTH - 1 - p);
    end
  end

  // Legality, expected rotation and saturating helpers.
  always_comb begin
    is_legal = (ring_in != '0) && ((ring_in & (ring_in - WIDTH'(1))) == '0);
    expected = {prev[0], prev[WIDTH-1:1]};
    in_order = (ring_in == expected);
    run_inc  = (run == RW'(LOCK_CNT)) ? run : run + RW'(1);
    err_now  = ring_vld && (!is_legal || (have_prev && !in_order));
    err_inc  = (err_cnt == ERR_MAX) ? err_cnt : err_cnt + ERR_W'(1);
  end

  // Lock FSM with decode, history tracking and registered pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_UNLOCKED;
      prev      <= '0;
      have_prev <= 1'b0;
      run       <= '0;
      phase     <= '0;
      phase_vld <= 1'b0;
      illegal   <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      phase_vld <= 1'b0;
      illegal   <= 1'b0;
      seq_err   <= 1'b0;
      if (ring_vld) begin
        if (!is_legal) begin
          illegal   <= 1'b1;
          have_prev <= 1'b0;
          run       <= '0;
          state     <= ST_UNLOCKED;
        end else begin
          phase     <= dec_phase;
          phase_vld <= 1'b1;
          prev      <= ring_in;
          have_prev <= 1'b1;
          if (!have_prev) begin
            // First legal sample after reset or an illegal code: no order check.
            run   <= RW'(1);
            state <= (LOCK_CNT == 1) ? ST_LOCKED : ST_ACQUIRE;
          end else if (in_order) begin
            run <= run_inc;
            if (run_inc == RW'(LOCK_CNT)) state <= ST_LOCKED;
          end else begin
            // Out of order (including a repeated code): restart acquisition.
            seq_err <= 1'b1;
            run     <= RW'(1);
            state   <= ST_ACQUIRE;
          end
        end
      end
    end
  end

  assign locked = (state == ST_LOCKED);

`ifdef RING_ERR_STICKY_EN
  // Saturating error counter and sticky flag; a new error beats err_clr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt    <= '0;
      err_sticky <= 1'b0;
    end else if (err_clr) begin
      err_cnt    <= err_now ? ERR_W'(1) : '0;
      err_sticky <= err_now;
    end else if (err_now) begin
      err_cnt    <= err_inc;
      err_sticky <= 1'b1;
    end
  end
`else
  // Saturating error counter, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt <= '0;
    end else if (err_now) begin
      err_cnt <= err_inc;
    end
  end
`endif

endmodule

// File: tb/tb_ring_decoder.sv
// tb_ring_decoder: scoreboard bench for ring_decoder. A driver pushes the
// reference model's expected outputs for every driven cycle into exp_q; a
// monitor pops one entry per clock and compares all outputs.
module tb_ring_decoder;

  localparam int WIDTH    = 4;
  localparam int LOCK_CNT = 3;
  localparam int ERR_W    = 3;
  localparam int PW       = $clog2(WIDTH);
  localparam int ERR_MAX  = (1 << ERR_W) - 1;

  typedef struct packed {
    logic [PW-1:0]    phase;
    logic             phase_vld;
    logic             illegal;
    logic             seq_err;
    logic             locked;
    logic [ERR_W-1:0] err_cnt;
    logic             sticky;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] ring_in;
  logic             ring_vld;
  logic             err_clr;
  logic [PW-1:0]    phase;
  logic             phase_vld, illegal, seq_err, locked;
  logic [ERR_W-1:0] err_cnt;
`ifdef RING_ERR_STICKY_EN
  logic             err_sticky;
`endif

  always #5 clk = ~clk;

  ring_decoder #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W)) dut (
    .clk(clk),
    .rst(rst),
    .ring_in(ring_in),
    .ring_vld(ring_vld),
`ifdef RING_ERR_STICKY_EN
    .err_clr(err_clr),
    .err_sticky(err_sticky),
`endif
    .phase(phase),
    .phase_vld(phase_vld),
    .illegal(illegal),
    .seq_err(seq_err),
    .locked(locked),
    .err_cnt(err_cnt)
  );

  // ---------------- reference model ----------------
  // Works on phase numbers: a legal sample is in order when its phase is the
  // previous phase plus one, modulo WIDTH.
  int   m_phase, m_prev_ph, m_run, m_err;
  bit   m_have, m_locked, m_sticky;

  function automatic void model_reset();
    m_phase = 0; m_prev_ph = 0; m_run = 0; m_err = 0;
    m_have = 0; m_locked = 0; m_sticky = 0;
  endfunction

  function automatic exp_t model_step(logic [WIDTH-1:0] code, logic vld, logic clr);
    exp_t e;
    bit   pv = 0, il = 0, se = 0, err = 0;
    int   ph = 0;
    if (vld) begin
      if ($countones(code) != 1) begin
        il = 1; err = 1;
        m_have = 0; m_run = 0; m_locked = 0;
      end else begin
        for (int p = 0; p < WIDTH; p++) if (code[p]) ph = WIDTH - 1 - p;
        pv = 1;
        m_phase = ph;
        if (!m_have) begin
          m_have = 1; m_run = 1;
          if (m_run >= LOCK_CNT) m_locked = 1;
        end else if (ph == (m_prev_ph + 1) % WIDTH) begin
          m_run = (m_run + 1 > LOCK_CNT) ? LOCK_CNT : m_run + 1;
          if (m_run == LOCK_CNT) m_locked = 1;
        end else begin
          se = 1; err = 1; m_run = 1; m_locked = 0;
        end
        m_prev_ph = ph;
      end
    end
`ifdef RING_ERR_STICKY_EN
    if (clr) begin
      m_err = err ? 1 : 0;
      m_sticky = err;
    end else if (err) begin
      m_err = (m_err < ERR_MAX) ? m_err + 1 : ERR_MAX;
      m_sticky = 1;
    end
`else
    if (clr && 1'b0) m_sticky = 0;
    if (err) m_err = (m_err < ERR_MAX) ? m_err + 1 : ERR_MAX;
`endif
    e.phase     = PW'(m_phase);
    e.phase_vld = pv;
    e.illegal   = il;
    e.seq_err   = se;
    e.locked    = m_locked;
    e.err_cnt   = ERR_W'(m_err);
    e.sticky    = m_sticky;
    return e;
  endfunction

  // ---------------- scoreboard ----------------
  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_fail = 0;
  bit   in_rst = 1'b1;

  function automatic exp_t get_act();
    exp_t a;
    a.phase     = phase;
    a.phase_vld = phase_vld;
    a.illegal   = illegal;
    a.seq_err   = seq_err;
    a.locked    = locked;
    a.err_cnt   = err_cnt;
`ifdef RING_ERR_STICKY_EN
    a.sticky    = err_sticky;
`else
    a.sticky    = 1'b0;
`endif
    return a;
  endfunction

  task automatic compare(input string name, input exp_t a, input exp_t e);
    n_vec++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s t=%0t got ph=%0d pv=%b il=%b se=%b lk=%b ec=%0d st=%b need ph=%0d pv=%b il=%b se=%b lk=%b ec=%0d st=%b",
               name, $time, a.phase, a.phase_vld, a.illegal, a.seq_err, a.locked, a.err_cnt, a.sticky,
               e.phase, e.phase_vld, e.illegal, e.seq_err, e.locked, e.err_cnt, e.sticky);
    end
  endtask

  // Monitor: one expected entry per driven cycle, checked 1 time unit after
  // the edge that registered it.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!in_rst && exp_q.size() > 0) compare("out_check", get_act(), exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [WIDTH-1:0] code, input logic vld, input logic clr);
    @(posedge clk);
    #3;
    ring_in  = code;
    ring_vld = vld;
    err_clr  = clr;
    exp_q.push_back(model_step(code, vld, clr));
  endtask

  task automatic send(input logic [WIDTH-1:0] code);
    drive(code, 1'b1, 1'b0);
  endtask

  task automatic idle_cycle();
    drive(WIDTH'($urandom_range(0, (1 << WIDTH) - 1)), 1'b0, 1'b0);
  endtask

  // Asynchronous reset asserted away from any edge; outputs must clear at once.
  task automatic apply_reset();
    @(posedge clk);
    #6;
    rst = 1'b0;
    in_rst = 1'b1;
    ring_vld = 1'b0;
    err_clr = 1'b0;
    exp_q.delete();
    model_reset();
    #1;
    compare("reset_clear", get_act(), exp_t'('0));
    @(negedge clk);
    rst = 1'b1;
    in_rst = 1'b0;
  endtask

  function automatic logic [WIDTH-1:0] code_of(int ph);
    logic [WIDTH-1:0] c;
    c = '0;
    c[WIDTH-1-ph] = 1'b1;
    return c;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [WIDTH-1:0] c;
    int r;
    rst = 1'b0; ring_in = '0; ring_vld = 1'b0; err_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare("reset_state", get_act(), exp_t'('0));
    @(negedge clk);
    rst = 1'b1;
    in_rst = 1'b0;

    // Lock acquisition with wrap 0001 -> 1000.
    send(4'b1000); send(4'b0100); send(4'b0010); send(4'b0001); send(4'b1000);
    // Multi-hot while locked, then restart without sequence check.
    send(4'b0110); send(4'b0001);
    // Relock, then skip a phase.
    send(4'b1000); send(4'b0100); send(4'b0001);
    send(4'b1000); send(4'b0100);
    // Valid gap is ignored.
    send(4'b0010); idle_cycle(); send(4'b0001);
    // Repeated code is a sequence error.
    send(4'b0001);
    // Error counter saturation.
    for (int i = 0; i < ERR_MAX + 2; i++) send(4'b0000);
    idle_cycle();
    apply_reset();
    send(4'b0100); send(4'b0010);

`ifdef RING_ERR_STICKY_EN
    send(4'b0000);
    idle_cycle();
    drive(4'b0000, 1'b0, 1'b1);
    send(4'b1000);
    drive(4'b1111, 1'b1, 1'b1);
    idle_cycle();
    drive(4'b0100, 1'b1, 1'b1);
`endif

    // Randomised bursts, each starting from reset.
    for (int b = 0; b < 20; b++) begin
      apply_reset();
      for (int i = 0; i < 60; i++) begin
        r = $urandom_range(0, 99);
        if (r < 60)      c = m_have ? code_of((m_prev_ph + 1) % WIDTH) : code_of($urandom_range(0, WIDTH - 1));
        else if (r < 80) c = code_of($urandom_range(0, WIDTH - 1));
        else if (r < 95) c = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
        else             c = '0;
        drive(c, ($urandom_range(0, 9) != 0), ($urandom_range(0, 19) == 0));
      end
    end

    idle_cycle();
    repeat (3) @(posedge clk);
    #2;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending entries need 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
